// File: rtl/dct_pkg.sv
// Shared constants, cosine table and helpers for the 8x8 DCT MAC datapath.
package dct_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COEF_W  = 8;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned OUT_W   = 12;
  localparam int unsigned FRAC_SH = 14;

  // cu*cv*ps product width: two COEF_W signed factors and a (PIX_W+1)-bit signed pixel
  localparam int unsigned PROD_W = 2 * COEF_W + PIX_W + 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  // C[k][n] = round(64 * ck * cos((2n+1) k pi / 16)), ck = 1/sqrt2 for k = 0
  localparam coef_t COS_TBL [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  // Half an output LSB, added before the arithmetic shift for round-half-up
  localparam logic signed [ACC_W:0] RND_BIAS =
    {{(ACC_W - FRAC_SH + 1){1'b0}}, 1'b1, {(FRAC_SH - 1){1'b0}}};

  function automatic coef_t cos_lookup(input logic [2:0] k, input logic [2:0] n);
    return COS_TBL[k][n];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W:0] val);
    logic [ACC_W-OUT_W+1:0] top_bits;
    top_bits = val[ACC_W:OUT_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      return val[OUT_W-1:0];
    end else if (val[ACC_W]) begin
      return {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W - 1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/dct_cos_lut.sv
// Combinational DCT cosine table lookup: (k, n) -> C[k][n].
module dct_cos_lut
  import dct_pkg::*;
(
  input  logic              [2:0]        i_k,
  input  logic              [2:0]        i_n,
  output logic signed       [COEF_W-1:0] o_coef
);

  always_comb begin
    o_coef = cos_lookup(i_k, i_n);
  end

endmodule

// File: rtl/dct_mac_datapath.sv
// Three-stage multiply-accumulate datapath producing one rounded 2-D DCT coefficient per block.
// Optional MAC-count checking is built when DCT_MAC_COUNT_CHECK_EN is defined.
module dct_mac_datapath
  import dct_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       u,
  input  logic [2:0]       v,
  input  logic [2:0]       x,
  input  logic [2:0]       y,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             active_MAC,
  input  logic             reset_MAC,
  input  logic             ready,
  input  logic [5:0]       address,
  output logic [OUT_W-1:0] out_data,
  output logic [5:0]       out_addr,
  output logic             out_write,
  output logic             count_error
);

  logic signed [COEF_W-1:0] w_cu;
  logic signed [COEF_W-1:0] w_cv;

  dct_cos_lut u_lut_ux (
    .i_k    (u),
    .i_n    (x),
    .o_coef (w_cu)
  );

  dct_cos_lut u_lut_vy (
    .i_k    (v),
    .i_n    (y),
    .o_coef (w_cv)
  );

  // S1
  logic                     r_ready_q;
  logic signed [PIX_W:0]    r_ps;
  logic signed [COEF_W-1:0] r_cu;
  logic signed [COEF_W-1:0] r_cv;
  logic                     r_act1;
  logic                     r_rst1;
  logic                     r_rdy1;
  logic [5:0]               r_addr1;

  // S2
  logic signed [ACC_W-1:0]  r_p2;
  logic                     r_act2;
  logic                     r_rst2;
  logic                     r_rdy2;
  logic [5:0]               r_addr2;

  // S3 / output
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [OUT_W-1:0]  r_out_data;
  logic [5:0]               r_out_addr;
  logic                     r_out_write;

  logic signed [PROD_W-1:0] w_cu_ext;
  logic signed [PROD_W-1:0] w_cv_ext;
  logic signed [PROD_W-1:0] w_ps_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_acc_d;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shifted;
  logic signed [OUT_W-1:0]  w_sat;

  always_comb begin
    w_cu_ext = {{(PROD_W - COEF_W){r_cu[COEF_W-1]}}, r_cu};
    w_cv_ext = {{(PROD_W - COEF_W){r_cv[COEF_W-1]}}, r_cv};
    w_ps_ext = {{(PROD_W - PIX_W - 1){r_ps[PIX_W]}}, r_ps};
    w_prod   = w_cu_ext * w_cv_ext * w_ps_ext;
  end

  // The written result always comes from the pre-clear sum, so a reset_MAC
  // aligned with ready only affects the next block.
  always_comb begin
    w_acc_next = r_act2 ? (r_acc + r_p2) : r_acc;
    w_acc_d    = r_rst2 ? (r_act2 ? r_p2 : '0) : w_acc_next;
    w_rnd      = {w_acc_next[ACC_W-1], w_acc_next} + RND_BIAS;
    w_shifted  = w_rnd >>> FRAC_SH;
    w_sat      = sat_out(w_shifted);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ready_q   <= 1'b0;
      r_ps        <= '0;
      r_cu        <= '0;
      r_cv        <= '0;
      r_act1      <= 1'b0;
      r_rst1      <= 1'b0;
      r_rdy1      <= 1'b0;
      r_addr1     <= '0;
      r_p2        <= '0;
      r_act2      <= 1'b0;
      r_rst2      <= 1'b0;
      r_rdy2      <= 1'b0;
      r_addr2     <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_write <= 1'b0;
    end else begin
      r_ready_q <= ready;
      r_ps      <= $signed({1'b0, pixel_data}) - 9'sd128;
      r_cu      <= w_cu;
      r_cv      <= w_cv;
      r_act1    <= active_MAC;
      r_rst1    <= reset_MAC;
      r_rdy1    <= ready & ~r_ready_q;
      r_addr1   <= address;

      r_p2    <= {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
      r_act2  <= r_act1;
      r_rst2  <= r_rst1;
      r_rdy2  <= r_rdy1;
      r_addr2 <= r_addr1;

      r_acc <= w_acc_d;
      if (r_rdy2) begin
        r_out_data  <= w_sat;
        r_out_addr  <= r_addr2;
        r_out_write <= 1'b1;
      end else begin
        r_out_write <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_write = r_out_write;

`ifdef DCT_MAC_COUNT_CHECK_EN
  logic [6:0] r_mac_cnt;
  logic [6:0] w_cnt_next;
  logic       r_count_error;

  // Saturate so a runaway block cannot wrap back to a legal-looking 64.
  always_comb begin
    w_cnt_next = (r_act2 && (r_mac_cnt != 7'h7f)) ? (r_mac_cnt + 7'd1) : r_mac_cnt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mac_cnt     <= '0;
      r_count_error <= 1'b0;
    end else begin
      r_mac_cnt <= r_rst2 ? {6'd0, r_act2} : w_cnt_next;
      if (r_rdy2 && (w_cnt_next != 7'd64)) begin
        r_count_error <= 1'b1;
      end
    end
  end

  assign count_error = r_count_error;
`else
  assign count_error = 1'b0;
`endif

endmodule
